// File: rtl/dk_walk_trigger_ctrl.sv
// dk_walk_trigger_ctrl
//
// Purpose:
//   Sequencer for the Donkey Kong walk sound path.
//   - Generates the sample-rate strobe audio_clk_en from clk with a phase accumulator.
//     The same strobe also clocks the other discrete blocks.
//   - Turns CPU walk-latch writes into a conditioned walk_en level.
//   - walk_en has a minimum on-time and a minimum off-time, honours a mute, and has an
//     optional watchdog.
//
// Optional feature:
//   Define DK_WALK_WATCHDOG_EN to build the watchdog.
//   - With it, ON exits after TO_N ticks without a cpu_wr.
//   - Without it, no watchdog logic exists and TIMEOUT_MS is ignored.
//
// Ports:
//   clk          in   system clock
//   I_RSTn       in   asynchronous active-low reset
//   cpu_wr       in   one-cycle write strobe to the walk latch
//   cpu_data     in   latch value, 1 = walk requested
//   mute         in   synchronous mute (level)
//   audio_clk_en out  one-cycle sample strobe (SAMPLE_RATE per CLOCK_RATE clocks)
//   walk_en      out  registered, conditioned walk request
//   state        out  FSM state: 0 idle, 1 on-hold, 2 on, 3 off-hold

module dk_walk_trigger_ctrl #(
  parameter int unsigned CLOCK_RATE  = 1000000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned MIN_ON_MS   = 20,
  parameter int unsigned MIN_OFF_MS  = 5,
  parameter int unsigned TIMEOUT_MS  = 100
) (
  input  logic       clk,
  input  logic       I_RSTn,
  input  logic       cpu_wr,
  input  logic       cpu_data,
  input  logic       mute,
  output logic       audio_clk_en,
  output logic       walk_en,
  output logic [1:0] state
);

  // Derived sample counts, computed in 64 bits so large parameters cannot wrap.
  localparam logic [63:0] OnNL  = 64'(SAMPLE_RATE) * 64'(MIN_ON_MS) / 64'd1000;
  localparam logic [63:0] OffNL = 64'(SAMPLE_RATE) * 64'(MIN_OFF_MS) / 64'd1000;
  localparam logic [15:0] OnN   = OnNL[15:0];
  localparam logic [15:0] OffN  = OffNL[15:0];

  if (CLOCK_RATE <= SAMPLE_RATE) begin : g_bad_rate
    $error("dk_walk_trigger_ctrl: CLOCK_RATE must exceed SAMPLE_RATE");
  end
  if (OnNL < 64'd1 || OnNL > 64'd65535) begin : g_bad_on
    $error("dk_walk_trigger_ctrl: ON_N out of range 1..65535");
  end
  if (OffNL < 64'd1 || OffNL > 64'd65535) begin : g_bad_off
    $error("dk_walk_trigger_ctrl: OFF_N out of range 1..65535");
  end

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOnHold  = 2'd1,
    StOn      = 2'd2,
    StOffHold = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        strobe_q, strobe_d;
  logic        req_q, req_d;
  logic [15:0] cnt_q, cnt_d;
  logic        walk_q, walk_d;
  logic [32:0] acc_sum;
  logic        wd_trip;

  // ---------------------------------------------------------------------------
  // Sample strobe: exact fractional divider, no drift over CLOCK_RATE clocks.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_sum  = {1'b0, acc_q} + 33'(SAMPLE_RATE);
    acc_d    = acc_sum[31:0];
    strobe_d = 1'b0;
    if (acc_sum >= 33'(CLOCK_RATE)) begin
      acc_d    = 32'(acc_sum - 33'(CLOCK_RATE));
      strobe_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog on the ON state.
  // ---------------------------------------------------------------------------
`ifdef DK_WALK_WATCHDOG_EN
  localparam logic [63:0] ToNL = 64'(SAMPLE_RATE) * 64'(TIMEOUT_MS) / 64'd1000;
  localparam logic [15:0] ToN  = ToNL[15:0];

  if (ToNL < 64'd1 || ToNL > 64'd65535) begin : g_bad_to
    $error("dk_walk_trigger_ctrl: TO_N out of range 1..65535");
  end

  logic [15:0] wd_q, wd_d;

  // A write on the trip tick counts as a refresh, so it suppresses the trip.
  assign wd_trip = (state_q == StOn) && strobe_q && !cpu_wr && (wd_q == ToN - 16'd1);

  always_comb begin
    wd_d = wd_q;
    if (cpu_wr || (state_d == StOn && state_q != StOn)) begin
      wd_d = '0;
    end else if (state_q == StOn && strobe_q) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request latch and FSM next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_d = req_q;
    if (mute || wd_trip) begin
      req_d = 1'b0;
    end else if (cpu_wr) begin
      req_d = cpu_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_q && !mute) state_d = StOnHold;
      end
      StOnHold: begin
        if (mute) begin
          state_d = StOffHold;
        end else if (strobe_q && cnt_q == OnN - 16'd1) begin
          state_d = req_q ? StOn : StOffHold;
        end
      end
      StOn: begin
        if (!req_q || mute || wd_trip) state_d = StOffHold;
      end
      StOffHold: begin
        if (strobe_q && cnt_q == OffN - 16'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // cnt measures ticks since entry into the current state.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (strobe_q) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Registered from the next state so walk_en moves on the same edge as state.
  always_comb begin
    walk_d = (state_d == StOnHold) || (state_d == StOn);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      acc_q    <= '0;
      strobe_q <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
      state_q  <= StIdle;
      walk_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      strobe_q <= strobe_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      walk_q   <= walk_d;
    end
  end

  assign audio_clk_en = strobe_q;
  assign walk_en      = walk_q;
  assign state        = state_q;

endmodule

// File: tb/tb_dk_walk_trigger_ctrl.sv
// Directed testbench for dk_walk_trigger_ctrl.
// Uses short hold times so every scenario completes quickly:
//   MIN_ON_MS=2 gives ON_N=96, MIN_OFF_MS=1 gives OFF_N=48, TIMEOUT_MS=4 gives TO_N=192.
// The rates stay at 1 MHz / 48 kHz.

module tb_dk_walk_trigger_ctrl;

  localparam int ON_N  = 96;
  localparam int OFF_N = 48;
  localparam int TO_N  = 192;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONH  = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_OFFH = 2'd3;

  logic       clk;
  logic       I_RSTn;
  logic       cpu_wr;
  logic       cpu_data;
  logic       mute;
  logic       audio_clk_en;
  logic       walk_en;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // Cumulative count of ticks consumed at an edge, per pre-edge state and while walk_en high.
  int st_ticks [4];
  int walk_ticks = 0;

  dk_walk_trigger_ctrl #(
    .CLOCK_RATE (1000000),
    .SAMPLE_RATE(48000),
    .MIN_ON_MS  (2),
    .MIN_OFF_MS (1),
    .TIMEOUT_MS (4)
  ) dut (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .cpu_wr      (cpu_wr),
    .cpu_data    (cpu_data),
    .mute        (mute),
    .audio_clk_en(audio_clk_en),
    .walk_en     (walk_en),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) st_ticks[i] = 0;
  end

  always @(posedge clk) begin
    if (I_RSTn && audio_clk_en) begin
      st_ticks[state] <= st_ticks[state] + 1;
      if (walk_en) walk_ticks <= walk_ticks + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wr(input logic d);
    cpu_wr   = 1'b1;
    cpu_data = d;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (state === st) ok = 1'b1;
      else step();
    end
    if (state === st) ok = 1'b1;
  endtask

  task automatic test_reset();
    I_RSTn = 1'b0; cpu_wr = 1'b0; cpu_data = 1'b0; mute = 1'b0;
    repeat (3) step();
    tests++; if (audio_clk_en !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %0b expected 0", audio_clk_en); end
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL reset_walk: got %0b expected 0", walk_en); end
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
  endtask

  task automatic test_cadence();
    int first = 0, prev = 0, count = 0, bad_iv = 0;
    I_RSTn = 1'b1;
    for (int n = 1; n <= 12500; n++) begin
      step();
      if (audio_clk_en === 1'b1) begin
        if (first == 0) first = n;
        else if ((n - prev) != 20 && (n - prev) != 21) bad_iv++;
        prev = n;
        count++;
      end
    end
    tests++; if (first != 21) begin fails++; $display("FAIL cadence_first: got edge %0d expected 21", first); end
    tests++; if (count != 600) begin fails++; $display("FAIL cadence_count: got %0d expected 600", count); end
    tests++; if (bad_iv != 0) begin fails++; $display("FAIL cadence_interval: got %0d bad expected 0", bad_iv); end
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL cadence_idle: got %0d expected 0", state); end
  endtask

  task automatic test_short();
    int s1, s2, s3, sw;
    bit ok;
    pulse_wr(1'b1);
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL short_edge1_walk: got %0b expected 0", walk_en); end
    step();
    tests++; if (walk_en !== 1'b1) begin fails++; $display("FAIL short_edge2_walk: got %0b expected 1", walk_en); end
    tests++; if (state !== S_ONH) begin fails++; $display("FAIL short_edge2_state: got %0d expected 1", state); end
    s1 = st_ticks[1]; s2 = st_ticks[2]; sw = walk_ticks;
    for (int i = 0; i < 1000 && (st_ticks[1] - s1) < 10; i++) step();
    pulse_wr(1'b0);
    wait_state(S_OFFH, 5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL short_reach_offhold: got state %0d expected 3", state); end
    tests++; if (st_ticks[1] - s1 != ON_N) begin fails++; $display("FAIL short_onhold_ticks: got %0d expected %0d", st_ticks[1] - s1, ON_N); end
    tests++; if (walk_ticks - sw != ON_N) begin fails++; $display("FAIL short_walk_ticks: got %0d expected %0d", walk_ticks - sw, ON_N); end
    tests++; if (st_ticks[2] - s2 != 0) begin fails++; $display("FAIL short_no_on: got %0d expected 0", st_ticks[2] - s2); end
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL short_offhold_walk: got %0b expected 0", walk_en); end
    s3 = st_ticks[3];
    wait_state(S_IDLE, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL short_reach_idle: got state %0d expected 0", state); end
    tests++; if (st_ticks[3] - s3 != OFF_N) begin fails++; $display("FAIL short_offhold_ticks: got %0d expected %0d", st_ticks[3] - s3, OFF_N); end
  endtask

  task automatic test_long_hold();
    int s1, s2, s3, sw, d, last, glitch;
    bit ok;
    glitch = 0; last = -1;
    pulse_wr(1'b1);
    step();
    s1 = st_ticks[1]; s2 = st_ticks[2]; sw = walk_ticks;
    for (int i = 0; i < 20000; i++) begin
      step();
      cpu_wr = 1'b0;
      if (walk_en !== 1'b1) glitch++;
      d = walk_ticks - sw;
      if (d >= 300) break;
      if (d > 0 && d % 10 == 0 && d != last) begin
        cpu_wr = 1'b1; cpu_data = 1'b1; last = d;
      end
    end
    pulse_wr(1'b0);
    wait_state(S_OFFH, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL long_reach_offhold: got state %0d expected 3", state); end
    tests++; if (walk_ticks - sw != 300) begin fails++; $display("FAIL long_walk_ticks: got %0d expected 300", walk_ticks - sw); end
    tests++; if (st_ticks[1] - s1 != ON_N) begin fails++; $display("FAIL long_onhold_ticks: got %0d expected %0d", st_ticks[1] - s1, ON_N); end
    tests++; if (st_ticks[2] - s2 != 300 - ON_N) begin fails++; $display("FAIL long_on_ticks: got %0d expected %0d", st_ticks[2] - s2, 300 - ON_N); end
    tests++; if (glitch != 0) begin fails++; $display("FAIL long_glitch: got %0d low samples expected 0", glitch); end
    s3 = st_ticks[3];
    wait_state(S_IDLE, 3000, ok);
    tests++; if (st_ticks[3] - s3 != OFF_N) begin fails++; $display("FAIL long_offhold_ticks: got %0d expected %0d", st_ticks[3] - s3, OFF_N); end
  endtask

  task automatic test_retrigger();
    int s3, glitch;
    bit ok;
    glitch = 0;
    pulse_wr(1'b1);
    step();
    pulse_wr(1'b0);
    wait_state(S_OFFH, 5000, ok);
    s3 = st_ticks[3];
    for (int i = 0; i < 1000 && (st_ticks[3] - s3) < 20; i++) step();
    pulse_wr(1'b1);
    for (int i = 0; i < 3000 && state !== S_IDLE; i++) begin
      if (walk_en !== 1'b0) glitch++;
      step();
    end
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL retrig_reach_idle: got state %0d expected 0", state); end
    tests++; if (glitch != 0) begin fails++; $display("FAIL retrig_offhold_walk: got %0d high samples expected 0", glitch); end
    tests++; if (st_ticks[3] - s3 != OFF_N) begin fails++; $display("FAIL retrig_offhold_ticks: got %0d expected %0d", st_ticks[3] - s3, OFF_N); end
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL retrig_idle_walk: got %0b expected 0", walk_en); end
    step();
    tests++; if (walk_en !== 1'b1) begin fails++; $display("FAIL retrig_rise_walk: got %0b expected 1", walk_en); end
    tests++; if (state !== S_ONH) begin fails++; $display("FAIL retrig_rise_state: got %0d expected 1", state); end
    pulse_wr(1'b0);
    wait_state(S_OFFH, 5000, ok);
    wait_state(S_IDLE, 3000, ok);
  endtask

  task automatic test_mute();
    int s1, bad;
    bit ok;
    bad = 0;
    pulse_wr(1'b1);
    step();
    s1 = st_ticks[1];
    for (int i = 0; i < 1000 && (st_ticks[1] - s1) < 5; i++) step();
    mute = 1'b1; cpu_wr = 1'b1; cpu_data = 1'b1;
    step();
    cpu_wr = 1'b0;
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL mute_walk: got %0b expected 0", walk_en); end
    tests++; if (state !== S_OFFH) begin fails++; $display("FAIL mute_state: got %0d expected 3", state); end
    wait_state(S_IDLE, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mute_reach_idle: got state %0d expected 0", state); end
    pulse_wr(1'b1);
    for (int i = 0; i < 200; i++) begin
      if (state !== S_IDLE) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL mute_idle_hold: got %0d non-idle samples expected 0", bad); end
    mute = 1'b0;
    repeat (50) step();
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL mute_req_cleared: got state %0d expected 0", state); end
  endtask

  task automatic test_watchdog();
    int s1, s2;
    bit ok;
    pulse_wr(1'b1);
    step();
    s1 = st_ticks[1];
    wait_state(S_ON, 5000, ok);
    tests++; if (st_ticks[1] - s1 != ON_N) begin fails++; $display("FAIL wd_onhold_ticks: got %0d expected %0d", st_ticks[1] - s1, ON_N); end
    s2 = st_ticks[2];
`ifdef DK_WALK_WATCHDOG_EN
    wait_state(S_OFFH, 8000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wd_trip: got state %0d expected 3", state); end
    tests++; if (st_ticks[2] - s2 != TO_N) begin fails++; $display("FAIL wd_on_ticks: got %0d expected %0d", st_ticks[2] - s2, TO_N); end
    wait_state(S_IDLE, 3000, ok);
    repeat (50) step();
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL wd_req_cleared: got state %0d expected 0", state); end
`else
    for (int i = 0; i < 9000 && (st_ticks[2] - s2) < TO_N + 20; i++) step();
    tests++; if (state !== S_ON) begin fails++; $display("FAIL wd_off_state: got %0d expected 2", state); end
    tests++; if (walk_en !== 1'b1) begin fails++; $display("FAIL wd_off_walk: got %0b expected 1", walk_en); end
    pulse_wr(1'b0);
    wait_state(S_OFFH, 100, ok);
    wait_state(S_IDLE, 3000, ok);
`endif
  endtask

  task automatic test_reset_mid_burst();
    pulse_wr(1'b1);
    step();
    step();
    #2;
    I_RSTn = 1'b0;
    #1;
    tests++; if (walk_en !== 1'b0) begin fails++; $display("FAIL rst_async_walk: got %0b expected 0", walk_en); end
    tests++; if (state !== S_IDLE) begin fails++; $display("FAIL rst_async_state: got %0d expected 0", state); end
    step();
    I_RSTn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_short();
    test_long_hold();
    test_retrigger();
    test_mute();
    test_watchdog();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dk_walk_trigger_ctrl.md
# dk_walk_trigger_ctrl

Sequencer for the Donkey Kong walk sound path. It generates the sample-rate strobe `audio_clk_en` from `clk` and turns CPU sound-latch writes into a conditioned `walk_en` level for the walk discrete circuit. The conditioning enforces a minimum on-time and a minimum off-time, supports a mute, and optionally applies a watchdog timeout. It sits between the CPU sound-latch decode and the walk discrete chain, and its strobe also clocks the other discrete blocks.

## Interface
- `CLOCK_RATE`, 1000000: `clk` frequency in Hz; must be greater than `SAMPLE_RATE`.
- `SAMPLE_RATE`, 48000: `audio_clk_en` rate in Hz.
- `MIN_ON_MS`, 20: minimum `walk_en` high time.
- `MIN_OFF_MS`, 5: minimum `walk_en` low time after a burst.
- `TIMEOUT_MS`, 100: watchdog period.
- Derived sample counts:
  - `ON_N = SAMPLE_RATE*MIN_ON_MS/1000` (960)
  - `OFF_N = SAMPLE_RATE*MIN_OFF_MS/1000` (240)
  - `TO_N = SAMPLE_RATE*TIMEOUT_MS/1000` (4800)
  - Each must be in 1..65535; elaboration error otherwise.
- Ports (reset I_RSTn, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock.
- `I_RSTn`  in  1  asynchronous active-low reset.
- `cpu_wr`  in  1  one-cycle write strobe to the walk latch.
- `cpu_data`  in  1  latch value; 1 means walk requested.
- `mute`  in  1  synchronous mute, level.
- `audio_clk_en`  out  1  one-cycle sample strobe.
- `walk_en`  out  1  conditioned walk request to the discrete circuit.
- `state`  out  2  FSM state: IDLE=0, ON_HOLD=1, ON=2, OFF_HOLD=3.

## Operation
- Strobe generator:
  - 32-bit accumulator `acc`.
  - Each clk: `nxt = acc + SAMPLE_RATE`.
  - If `nxt >= CLOCK_RATE`: `acc <= nxt - CLOCK_RATE` and `audio_clk_en <= 1`.
  - Otherwise: `acc <= nxt` and `audio_clk_en <= 0`.
  - Result is exactly `SAMPLE_RATE` strobes per `CLOCK_RATE` clocks, with intervals of 20 or 21 clocks at the defaults.
- Request register `req`:
  - `cpu_wr` loads `req <= cpu_data`.
  - `mute` clears `req`; `mute` wins over a simultaneous `cpu_wr`.
- Sample counter `cnt` (16 bit): cleared on every state change; otherwise increments on `audio_clk_en`.
- FSM (all transitions on clk edges):
  - IDLE: `req=1` and `mute=0` → ON_HOLD. This transition is not tick-gated.
  - ON_HOLD:
    - `mute` → OFF_HOLD.
    - On the tick where `cnt == ON_N-1`: → ON if `req`, else → OFF_HOLD.
  - ON:
    - `req=0` or `mute` → OFF_HOLD.
    - Watchdog trip (see Configuration) → OFF_HOLD and clear `req`.
  - OFF_HOLD: on the tick where `cnt == OFF_N-1` → IDLE. Requests arriving during OFF_HOLD are held in `req` and serviced from IDLE.
- `walk_en` is registered. It is 1 in ON_HOLD and ON, 0 in IDLE and OFF_HOLD. It updates on the same edge as `state`.
- Watchdog counter (16 bit):
  - Cleared by any `cpu_wr` and on entry to ON.
  - Increments on ticks while in ON.
  - Trips on the tick where the count equals `TO_N-1`.

## Timing
- Reset values: `acc=0`, `audio_clk_en=0`, `req=0`, `cnt=0`, watchdog count 0, `state=IDLE`, `walk_en=0`.
- Reset asserted mid-burst drops `walk_en` to 0 asynchronously.
- First strobe appears after the 21st rising edge following reset release (21·48000 ≥ 1e6).
- Latency from `cpu_wr` (data 1) in IDLE to `walk_en`: `req` sets at edge 1 and `walk_en` rises at edge 2.
- `mute` with `walk_en=1`: `walk_en` falls on the next edge.
- Minimum high time is exactly `ON_N` ticks. It is measured from the first tick after entry, so on-time is `ON_N` ticks plus up to one strobe interval.
- Minimum low time follows the same rule with `OFF_N`.
- `cpu_wr` with data 1 while already in ON only restarts the watchdog; there is no glitch on `walk_en`.

## Configuration
- `DK_WALK_WATCHDOG_EN` defined: the watchdog is compiled in and ON exits after `TO_N` ticks without a `cpu_wr`.
- `DK_WALK_WATCHDOG_EN` undefined: no watchdog logic is built, `TIMEOUT_MS` is ignored, and ON persists until `req=0` or `mute`.

## Test plan
- Strobe cadence: reset release, then run 1,000,000 clocks → exactly 48000 strobes, first after edge 21, every interval 20 or 21.
- Short request: `cpu_wr` with 1, then `cpu_wr` with 0 after 10 ticks → `walk_en` rises 2 edges after the first write, stays high for 960 ticks, then is low for 240 ticks (OFF_HOLD), then `state=IDLE`.
- Long hold: write 1, then write 0 after 3000 ticks with refresh writes every 50 ticks → `walk_en` high about 3000 ticks; OFF_HOLD lasts 240 ticks.
- Retrigger in OFF_HOLD: write 1 at OFF_HOLD tick 100 → `walk_en` stays 0 until OFF_HOLD completes, then rises 1 edge after IDLE is entered.
- Mute: `mute=1` during ON_HOLD, simultaneous with `cpu_wr` data 1 → `walk_en` 0 on next edge, `req=0`, OFF_HOLD entered, and IDLE is held while `mute=1`.
- Watchdog (macro defined): write 1 once, then no further writes → ON entered at tick 960, OFF_HOLD at tick 960+4800, `req=0`. With the macro undefined, `walk_en` stays high indefinitely.
